// File: rtl/dataloop_seq_pkg.sv
// Shared types for the data-loop sequencer: opcodes, FSM states, loop control bundle
// and instruction field placement helpers.
package dataloop_seq_pkg;

  localparam int unsigned OpWidth = 4;
  // Register fields sit above the immediate in this order (index * AW above BitWidth)
  localparam int unsigned RbField = 0;
  localparam int unsigned RaField = 1;
  localparam int unsigned RdField = 2;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADDI = 4'd3,
    OP_OR   = 4'd4,
    OP_ORN  = 4'd5,
    OP_CMP  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_ROL  = 4'd9,
    OP_LD   = 4'd10,
    OP_ST   = 4'd11,
    OP_LI   = 4'd12
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    LS_ADDR = 3'd2,
    MEM     = 3'd3,
    LD_WB   = 3'd4
  } state_e;

  typedef struct packed {
    logic EnA;
    logic EnB;
    logic InvA;
    logic InvB;
    logic cIn;
    logic ImmEnB;
    logic ORen;
    logic ShiftEn;
    logic ShiftByA;
    logic ShiftLeft;
    logic ShiftRotateEnable;
    logic RegWriteEn;
    logic OutputOverrideEnable;
    logic clk_en;
  } dl_ctrl_t;

  function automatic int unsigned fieldLsb(input int unsigned field, input int unsigned aw,
                                           input int unsigned bw);
    return bw + field * aw;
  endfunction

endpackage

// File: rtl/dataloop_decode.sv
// Combinational opcode decode: loop control bits plus legal / writes / setsFlags.
module dataloop_decode
  import dataloop_seq_pkg::*;
#(
  parameter int unsigned ShifterEnabled = 0
) (
  input  logic [OpWidth-1:0] op,
  output dl_ctrl_t           ctrl,
  output logic               legal,
  output logic               writes,
  output logic               setsFlags
);

  always_comb begin
    ctrl        = '0;
    ctrl.clk_en = 1'b1;
    legal       = 1'b1;
    writes      = 1'b0;
    setsFlags   = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD: begin
        ctrl.EnA = 1'b1; ctrl.EnB = 1'b1;
        writes = 1'b1; setsFlags = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        ctrl.EnA = 1'b1; ctrl.EnB = 1'b1; ctrl.InvB = 1'b1; ctrl.cIn = 1'b1;
        writes = (op == OP_SUB); setsFlags = 1'b1;
      end
      OP_ADDI: begin
        ctrl.EnA = 1'b1; ctrl.ImmEnB = 1'b1;
        writes = 1'b1; setsFlags = 1'b1;
      end
      OP_OR: begin
        ctrl.EnA = 1'b1; ctrl.EnB = 1'b1; ctrl.ORen = 1'b1;
        writes = 1'b1; setsFlags = 1'b1;
      end
      OP_ORN: begin
        ctrl.EnA = 1'b1; ctrl.EnB = 1'b1; ctrl.InvA = 1'b1; ctrl.InvB = 1'b1; ctrl.ORen = 1'b1;
        writes = 1'b1; setsFlags = 1'b1;
      end
      // Shift amount always comes from the immediate (ShiftByA stays 0)
      OP_SHL, OP_SHR, OP_ROL: begin
        if (ShifterEnabled != 0) begin
          ctrl.EnB = 1'b1; ctrl.ShiftEn = 1'b1;
          ctrl.ShiftLeft = (op != OP_SHR);
          ctrl.ShiftRotateEnable = (op == OP_ROL);
          writes = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_LD, OP_ST: ;
      OP_LI: begin
        ctrl.OutputOverrideEnable = 1'b1;
        writes = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    ctrl.RegWriteEn = writes;
  end

endmodule

// File: rtl/dataloop_sequencer.sv
// Instruction sequencer driving the dual-read RCA data loop, with a req/ack memory port.
// Optional DLSEQ_PERF_CNT_EN adds retired_cnt / stall_cnt performance counters.
module dataloop_sequencer
  import dataloop_seq_pkg::*;
#(
  parameter int unsigned BitWidth       = 8,
  parameter int unsigned RegisterCount  = 16,
  parameter int unsigned ZRenabled      = 0,
  parameter int unsigned ShifterEnabled = 0,
  localparam int unsigned AW            = $clog2(RegisterCount),
  localparam int unsigned InstrWidth    = OpWidth + 3 * AW + BitWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [InstrWidth-1:0] instr,
  output dl_ctrl_t              dl_ctrl,
  output logic [AW-1:0]         dl_regA,
  output logic [AW-1:0]         dl_regB,
  output logic [AW-1:0]         dl_regC,
  output logic [BitWidth-1:0]   dl_imm,
  output logic [BitWidth-1:0]   dl_ovr,
  input  logic [BitWidth-1:0]   dl_alu_out,
  input  logic [BitWidth-1:0]   dl_doutb,
  input  logic                  dl_cout,
  input  logic                  dl_zero,
  input  logic                  dl_ovf,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [BitWidth-1:0]   mem_addr,
  output logic [BitWidth-1:0]   mem_wdata,
  input  logic                  mem_ack,
  input  logic [BitWidth-1:0]   mem_rdata,
  output logic [2:0]            flags,
  output logic                  illegal_op
`ifdef DLSEQ_PERF_CNT_EN
  ,
  output logic [31:0]           retired_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned RbLsb = fieldLsb(RbField, AW, BitWidth);
  localparam int unsigned RaLsb = fieldLsb(RaField, AW, BitWidth);
  localparam int unsigned RdLsb = fieldLsb(RdField, AW, BitWidth);
  localparam int unsigned OpLsb = BitWidth + 3 * AW;

  state_e                  state, nextState;
  logic [InstrWidth-1:0]   ir;
  logic [BitWidth-1:0]     ldData;
  logic [OpWidth-1:0]      irOp, newOp;
  logic [AW-1:0]           irRd, irRa, irRb;
  logic [BitWidth-1:0]     irImm;
  logic                    take, irIsSt, rdKeep;
  dl_ctrl_t                decCtrl;
  logic                    decLegal, decWrites, decSetsFlags;

  assign irOp   = ir[OpLsb +: OpWidth];
  assign irRd   = ir[RdLsb +: AW];
  assign irRa   = ir[RaLsb +: AW];
  assign irRb   = ir[RbLsb +: AW];
  assign irImm  = ir[BitWidth-1:0];
  assign newOp  = instr[OpLsb +: OpWidth];
  assign take   = instr_valid & instr_ready;
  assign irIsSt = (irOp == OP_ST);
  // r0 stays zero when ZRenabled: suppress every write that targets it
  assign rdKeep = (ZRenabled == 0) || (irRd != '0);

  dataloop_decode #(.ShifterEnabled(ShifterEnabled)) u_decode (
    .op        (irOp),
    .ctrl      (decCtrl),
    .legal     (decLegal),
    .writes    (decWrites),
    .setsFlags (decSetsFlags)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE, EXEC: begin
        if (take) nextState = (newOp == OP_LD || newOp == OP_ST) ? LS_ADDR : EXEC;
        else      nextState = IDLE;
      end
      LS_ADDR: nextState = MEM;
      MEM:     if (mem_ack) nextState = irIsSt ? IDLE : LD_WB;
      LD_WB:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode from state and IR
  always_comb begin
    dl_ctrl        = '0;
    dl_ctrl.clk_en = 1'b1;
    dl_regA        = '0;
    dl_regB        = '0;
    dl_regC        = '0;
    dl_imm         = '0;
    dl_ovr         = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    illegal_op     = 1'b0;
    instr_ready    = 1'b0;
    case (state)
      IDLE: instr_ready = 1'b1;
      EXEC: begin
        instr_ready = 1'b1;
        if (decLegal) begin
          dl_ctrl            = decCtrl;
          dl_ctrl.RegWriteEn = decWrites & rdKeep;
          dl_regA            = irRa;
          dl_regB            = irRb;
          dl_regC            = irRd;
          dl_imm             = irImm;
          if (irOp == OP_LI) dl_ovr = irImm;
        end else begin
          illegal_op = 1'b1;
        end
      end
      LS_ADDR: begin
        dl_ctrl.EnA    = 1'b1;
        dl_ctrl.ImmEnB = 1'b1;
        dl_regA        = irRa;
        dl_imm         = irImm;
        if (irIsSt) begin
          dl_ctrl.EnB = 1'b1;
          dl_regB     = irRb;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = irIsSt;
      end
      LD_WB: begin
        dl_ctrl.OutputOverrideEnable = 1'b1;
        dl_ctrl.RegWriteEn           = rdKeep;
        dl_regC                      = irRd;
        dl_ovr                       = ldData;
      end
      default: ;
    endcase
  end

  // Datapath registers: IR, flags, memory address/data, load capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir        <= '0;
      ldData    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      flags     <= '0;
    end else begin
      if (take) ir <= instr;
      if (state == EXEC && decLegal && decSetsFlags) flags <= {dl_cout, dl_zero, dl_ovf};
      if (state == LS_ADDR) begin
        mem_addr <= dl_alu_out;
        if (irIsSt) mem_wdata <= dl_doutb;
      end
      if (state == MEM && mem_ack && !irIsSt) ldData <= mem_rdata;
    end
  end

`ifdef DLSEQ_PERF_CNT_EN
  logic retire;
  assign retire = (state == EXEC && decLegal) || (state == MEM && mem_ack && irIsSt) ||
                  (state == LD_WB);

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + 32'd1;
      if (state == MEM && !mem_ack) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dataloop_sequencer.sv
// Self-checking bench for dataloop_sequencer: each accepted instruction is expanded
// into the per-cycle outputs it must produce, then compared cycle by cycle.
module tb_dataloop_sequencer;
  import dataloop_seq_pkg::*;

  localparam int unsigned BW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned IW    = 4 + 3 * AW + BW;
  localparam int unsigned BodyW = IW - 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           instr_valid, instr_ready;
  logic [IW-1:0]  instr;
  dl_ctrl_t       dl_ctrl;
  logic [AW-1:0]  dl_regA, dl_regB, dl_regC;
  logic [BW-1:0]  dl_imm, dl_ovr, dl_alu_out, dl_doutb;
  logic           dl_cout, dl_zero, dl_ovf;
  logic           mem_req, mem_we, mem_ack;
  logic [BW-1:0]  mem_addr, mem_wdata, mem_rdata;
  logic [2:0]     flags;
  logic           illegal_op;
`ifdef DLSEQ_PERF_CNT_EN
  logic [31:0]    retired_cnt, stall_cnt;
`endif

  dataloop_sequencer #(
    .BitWidth(BW), .RegisterCount(16), .ZRenabled(0), .ShifterEnabled(0)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .dl_ctrl(dl_ctrl), .dl_regA(dl_regA), .dl_regB(dl_regB), .dl_regC(dl_regC),
    .dl_imm(dl_imm), .dl_ovr(dl_ovr), .dl_alu_out(dl_alu_out), .dl_doutb(dl_doutb),
    .dl_cout(dl_cout), .dl_zero(dl_zero), .dl_ovf(dl_ovf),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .flags(flags), .illegal_op(illegal_op)
`ifdef DLSEQ_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // What the outputs must look like in one cycle, plus what the bench drives then
  typedef struct {
    bit            ready;
    dl_ctrl_t      ctrl;
    logic [AW-1:0] regA, regB, regC;
    logic [BW-1:0] imm, ovr, rdata;
    bit            memReq, memWe, illegal, ack, setsFlags, lsAddr, isSt, retire;
  } cyc_t;

  cyc_t          cur;
  cyc_t          pend[$];
  logic [2:0]    mFlags;
  logic [BW-1:0] mAddr, mWdata;
  int unsigned   mRetired, mStall;
  int            checks = 0;
  int            errors = 0;
  bit            fixEn;
  logic [BW-1:0] fixAlu, fixDoutb;
  logic [2:0]    fixFlags;
  int unsigned   nextWait;
  logic [BW-1:0] nextRdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t blankRec();
    cyc_t r;
    r.ready = 1'b0; r.ctrl = '0; r.ctrl.clk_en = 1'b1;
    r.regA = '0; r.regB = '0; r.regC = '0; r.imm = '0; r.ovr = '0; r.rdata = '0;
    r.memReq = 1'b0; r.memWe = 1'b0; r.illegal = 1'b0; r.ack = 1'b0;
    r.setsFlags = 1'b0; r.lsAddr = 1'b0; r.isSt = 1'b0; r.retire = 1'b0;
    return r;
  endfunction

  function automatic cyc_t idleRec();
    cyc_t r;
    r = blankRec();
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic logic [IW-1:0] mk(input int unsigned op, input int unsigned rd,
                                       input int unsigned ra, input int unsigned rb,
                                       input int unsigned imm);
    return {4'(op), AW'(rd), AW'(ra), AW'(rb), BW'(imm)};
  endfunction

  // Expand one accepted instruction into its expected cycle sequence
  task automatic expand(input logic [IW-1:0] w);
    cyc_t          r;
    int unsigned   op;
    logic [AW-1:0] rd, ra, rb;
    logic [BW-1:0] imm;
    op  = 32'(w[IW-1 -: 4]);
    rd  = w[BW + 2*AW +: AW];
    ra  = w[BW + AW +: AW];
    rb  = w[BW +: AW];
    imm = w[BW-1:0];
    if (op == 10 || op == 11) begin
      r = blankRec();
      r.lsAddr = 1'b1; r.isSt = (op == 11);
      r.ctrl.EnA = 1'b1; r.ctrl.ImmEnB = 1'b1; r.regA = ra; r.imm = imm;
      if (op == 11) begin r.ctrl.EnB = 1'b1; r.regB = rb; end
      pend.push_back(r);
      for (int i = 0; i <= int'(nextWait); i++) begin
        r = blankRec();
        r.memReq = 1'b1; r.memWe = (op == 11); r.isSt = (op == 11);
        if (i == int'(nextWait)) begin
          r.ack = 1'b1; r.rdata = nextRdata; r.retire = (op == 11);
        end
        pend.push_back(r);
      end
      if (op == 10) begin
        r = blankRec();
        r.ctrl.OutputOverrideEnable = 1'b1; r.ctrl.RegWriteEn = 1'b1;
        r.regC = rd; r.ovr = nextRdata; r.retire = 1'b1;
        pend.push_back(r);
      end
    end else begin
      r = idleRec();
      if (op > 12 || (op >= 7 && op <= 9)) begin
        r.illegal = 1'b1;
      end else begin
        r.regA = ra; r.regB = rb; r.regC = rd; r.imm = imm; r.retire = 1'b1;
        r.setsFlags = (op >= 1 && op <= 6);
        case (op)
          1: {r.ctrl.EnA, r.ctrl.EnB, r.ctrl.RegWriteEn} = 3'b111;
          2: {r.ctrl.EnA, r.ctrl.EnB, r.ctrl.InvB, r.ctrl.cIn, r.ctrl.RegWriteEn} = 5'b11111;
          3: {r.ctrl.EnA, r.ctrl.ImmEnB, r.ctrl.RegWriteEn} = 3'b111;
          4: {r.ctrl.EnA, r.ctrl.EnB, r.ctrl.ORen, r.ctrl.RegWriteEn} = 4'b1111;
          5: {r.ctrl.EnA, r.ctrl.EnB, r.ctrl.InvA, r.ctrl.InvB, r.ctrl.ORen,
              r.ctrl.RegWriteEn} = 6'b111111;
          6: {r.ctrl.EnA, r.ctrl.EnB, r.ctrl.InvB, r.ctrl.cIn} = 4'b1111;
          12: begin
            r.ctrl.OutputOverrideEnable = 1'b1; r.ctrl.RegWriteEn = 1'b1; r.ovr = imm;
          end
          default: ;
        endcase
      end
      pend.push_back(r);
    end
  endtask

  task automatic compareCur();
    chk("instr_ready", 32'(instr_ready), 32'(cur.ready));
    chk("dl_ctrl", 32'(dl_ctrl), 32'(cur.ctrl));
    chk("dl_regA", 32'(dl_regA), 32'(cur.regA));
    chk("dl_regB", 32'(dl_regB), 32'(cur.regB));
    chk("dl_regC", 32'(dl_regC), 32'(cur.regC));
    chk("dl_imm", 32'(dl_imm), 32'(cur.imm));
    chk("dl_ovr", 32'(dl_ovr), 32'(cur.ovr));
    chk("mem_req", 32'(mem_req), 32'(cur.memReq));
    chk("mem_we", 32'(mem_we), 32'(cur.memWe));
    chk("illegal_op", 32'(illegal_op), 32'(cur.illegal));
    chk("flags", 32'(flags), 32'(mFlags));
    chk("mem_addr", 32'(mem_addr), 32'(mAddr));
    chk("mem_wdata", 32'(mem_wdata), 32'(mWdata));
`ifdef DLSEQ_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, 32'(mRetired));
    chk("stall_cnt", stall_cnt, 32'(mStall));
`endif
  endtask

  // One cycle: check this cycle, drive inputs, advance the model, move to next negedge
  task automatic step(input bit v, input logic [IW-1:0] w);
    logic [BW-1:0] alu, db;
    logic [2:0]    fl;
    compareCur();
    alu = fixEn ? fixAlu : BW'($urandom);
    db  = fixEn ? fixDoutb : BW'($urandom);
    fl  = fixEn ? fixFlags : 3'($urandom);
    instr_valid = v;
    instr       = w;
    dl_alu_out  = alu;
    dl_doutb    = db;
    {dl_cout, dl_zero, dl_ovf} = fl;
    mem_ack     = cur.memReq ? cur.ack : 1'($urandom);
    mem_rdata   = (cur.memReq && cur.ack) ? cur.rdata : BW'($urandom);
    if (cur.setsFlags) mFlags = fl;
    if (cur.lsAddr) begin
      mAddr = alu;
      if (cur.isSt) mWdata = db;
    end
    if (cur.retire) mRetired++;
    if (cur.memReq && !cur.ack) mStall++;
    if (v && cur.ready) expand(w);
    cur = (pend.size() > 0) ? pend.pop_front() : idleRec();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; dl_alu_out = '0; dl_doutb = '0;
    dl_cout = 1'b0; dl_zero = 1'b0; dl_ovf = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    fixEn = 1'b0; fixAlu = '0; fixDoutb = '0; fixFlags = '0;
    nextWait = 0; nextRdata = '0;
    mFlags = '0; mAddr = '0; mWdata = '0; mRetired = 0; mStall = 0;
    cur = idleRec();
    #12;
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_ctrl", 32'(dl_ctrl), 32'h1);
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD r3,r1,r2 then SUB r4,r3,r1 back to back
    step(1'b1, mk(1, 3, 1, 2, 0));
    chk("t1_add_ctrl", 32'({dl_ctrl.EnA, dl_ctrl.EnB, dl_ctrl.RegWriteEn}), 32'h7);
    chk("t1_add_regC", 32'(dl_regC), 32'd3);
    step(1'b1, mk(2, 4, 3, 1, 0));
    chk("t1_sub_ctrl", 32'({dl_ctrl.InvB, dl_ctrl.cIn, dl_ctrl.RegWriteEn}), 32'h7);
    chk("t1_sub_regC", 32'(dl_regC), 32'd4);
    chk("t1_ready", 32'(instr_ready), 32'd1);
    step(1'b0, '0);

    // LD r5,[r1+4]: address 0x24, ack on third request cycle, data 0xA5
    fixEn = 1'b1; fixAlu = 8'h24; fixDoutb = 8'h11; fixFlags = 3'b000;
    nextWait = 2; nextRdata = 8'hA5;
    step(1'b1, mk(10, 5, 1, 0, 4));
    chk("t2_ready_low", 32'(instr_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0);
      chk("t2_mem_req_held", 32'(mem_req), 32'd1);
    end
    chk("t2_mem_addr", 32'(mem_addr), 32'h24);
    step(1'b0, '0);
    chk("t2_wb_ovr", 32'(dl_ovr), 32'hA5);
    chk("t2_wb_regC", 32'(dl_regC), 32'd5);
    chk("t2_wb_req_off", 32'(mem_req), 32'd0);
    step(1'b0, '0);

    // ST [r2+1],r6 with store data 0x3C
    fixDoutb = 8'h3C; nextWait = 0;
    step(1'b1, mk(11, 0, 2, 6, 1));
    chk("t3_ls_nowrite", 32'(dl_ctrl.RegWriteEn), 32'd0);
    chk("t3_ls_regB", 32'(dl_regB), 32'd6);
    step(1'b0, '0);
    chk("t3_mem_we", 32'(mem_we), 32'd1);
    chk("t3_mem_wdata", 32'(mem_wdata), 32'h3C);
    chk("t3_mem_nowrite", 32'(dl_ctrl.RegWriteEn), 32'd0);
    step(1'b0, '0);

    // CMP with cout=1, zero=1
    fixFlags = 3'b110;
    step(1'b1, mk(6, 7, 1, 2, 0));
    chk("t4_cmp_nowrite", 32'(dl_ctrl.RegWriteEn), 32'd0);
    step(1'b0, '0);
    chk("t4_flags", 32'(flags), 32'b110);

    // Opcode 14 and SHL (shifter disabled) are both dropped
    fixEn = 1'b0;
    step(1'b1, mk(14, 1, 1, 1, 0));
    chk("t5_illegal14", 32'(illegal_op), 32'd1);
    chk("t5_illegal14_nowrite", 32'(dl_ctrl.RegWriteEn), 32'd0);
    step(1'b1, mk(7, 2, 1, 1, 3));
    chk("t5_illegal_shl", 32'(illegal_op), 32'd1);
    step(1'b0, '0);
    chk("t5_flags_kept", 32'(flags), 32'b110);
    chk("t5_pulse_done", 32'(illegal_op), 32'd0);

    // Reset while waiting on memory
    nextWait = 20;
    step(1'b1, mk(10, 2, 3, 0, 0));
    step(1'b0, '0);
    chk("t6_in_mem", 32'(mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_req_drop", 32'(mem_req), 32'd0);
    chk("t6_ready", 32'(instr_ready), 32'd1);
    pend.delete();
    cur = idleRec();
    mFlags = '0; mAddr = '0; mWdata = '0; mRetired = 0; mStall = 0;
    #1 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      nextWait  = $urandom_range(0, 3);
      nextRdata = BW'($urandom);
      step($urandom_range(0, 9) < 7, {4'($urandom), BodyW'($urandom)});
    end
    step(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
